// File: rtl/exe_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage.
// master = upstream pipeline driving ID/EX values; slave = exe_stage.
interface exe_stage_if;
  logic [4:0]  dest_in;
  logic [31:0] reg2_in;
  logic [31:0] val1_in;
  logic [31:0] val2_in;
  logic [31:0] pc_in;
  logic        br_taken_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;

  logic [31:0] alu_res;
  logic [31:0] reg2;
  logic [4:0]  dest;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en;
  logic [31:0] br_addr;
  logic        br_taken;
  logic        stall;

  modport master (
    output dest_in, reg2_in, val1_in, val2_in, pc_in, br_taken_in,
           exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
    input  alu_res, reg2, dest, mem_r_en, mem_w_en, wb_en,
           br_addr, br_taken, stall
  );

  modport slave (
    input  dest_in, reg2_in, val1_in, val2_in, pc_in, br_taken_in,
           exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
    output alu_res, reg2, dest, mem_r_en, mem_w_en, wb_en,
           br_addr, br_taken, stall
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, branch target, 32-cycle shift-add
// multiplier that stalls the front end, and the EX/MEM pipeline register.
module exe_stage (
  input  logic      clk,
  input  logic      rst,
  exe_stage_if.slave bus
);
  localparam logic [3:0] CMD_ADD = 4'b0000, CMD_SUB = 4'b0010,
                         CMD_AND = 4'b0100, CMD_OR  = 4'b0101,
                         CMD_NOR = 4'b0110, CMD_XOR = 4'b0111,
                         CMD_SLL = 4'b1000, CMD_SRA = 4'b1001,
                         CMD_SRL = 4'b1010, CMD_MUL = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier;
  logic [31:0] l_reg2;
  logic [4:0]  l_dest;
  logic        l_mem_r, l_mem_w, l_wb;
  logic [31:0] alu_out;
  logic [4:0]  shamt;
  logic        is_mul;

  assign shamt  = bus.val2_in[4:0];
  assign is_mul = (bus.exe_cmd_in == CMD_MUL);

  always_comb begin
    alu_out = '0;
    case (bus.exe_cmd_in)
      CMD_ADD: alu_out = bus.val1_in + bus.val2_in;
      CMD_SUB: alu_out = bus.val1_in - bus.val2_in;
      CMD_AND: alu_out = bus.val1_in & bus.val2_in;
      CMD_OR:  alu_out = bus.val1_in | bus.val2_in;
      CMD_NOR: alu_out = ~(bus.val1_in | bus.val2_in);
      CMD_XOR: alu_out = bus.val1_in ^ bus.val2_in;
      CMD_SLL: alu_out = bus.val1_in << shamt;
      CMD_SRA: alu_out = $unsigned($signed(bus.val1_in) >>> shamt);
      CMD_SRL: alu_out = bus.val1_in >> shamt;
      default: alu_out = '0;
    endcase
  end

  // Branch outputs bypass the register; suppressed while a multiply owns the stage.
  assign bus.br_addr  = bus.pc_in + {bus.val2_in[29:0], 2'b00};
  assign bus.br_taken = bus.br_taken_in && (state == IDLE) && !rst;
  assign bus.stall    = !rst && (((state == IDLE) && is_mul) || (state == MUL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      l_reg2       <= '0;
      l_dest       <= '0;
      l_mem_r      <= 1'b0;
      l_mem_w      <= 1'b0;
      l_wb         <= 1'b0;
      bus.alu_res  <= '0;
      bus.reg2     <= '0;
      bus.dest     <= '0;
      bus.mem_r_en <= 1'b0;
      bus.mem_w_en <= 1'b0;
      bus.wb_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand        <= bus.val1_in;
            mplier       <= bus.val2_in;
            acc          <= '0;
            cnt          <= '0;
            l_reg2       <= bus.reg2_in;
            l_dest       <= bus.dest_in;
            l_mem_r      <= bus.mem_r_en_in;
            l_mem_w      <= bus.mem_w_en_in;
            l_wb         <= bus.wb_en_in;
            bus.alu_res  <= '0;
            bus.reg2     <= '0;
            bus.dest     <= '0;
            bus.mem_r_en <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.wb_en    <= 1'b0;
            state        <= MUL;
          end else begin
            bus.alu_res  <= alu_out;
            bus.reg2     <= bus.reg2_in;
            bus.dest     <= bus.dest_in;
            bus.mem_r_en <= bus.mem_r_en_in;
            bus.mem_w_en <= bus.mem_w_en_in;
            bus.wb_en    <= bus.wb_en_in;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand        <= mcand << 1;
          mplier       <= mplier >> 1;
          cnt          <= cnt + 5'd1;
          bus.alu_res  <= '0;
          bus.reg2     <= '0;
          bus.dest     <= '0;
          bus.mem_r_en <= 1'b0;
          bus.mem_w_en <= 1'b0;
          bus.wb_en    <= 1'b0;
          if (cnt == 5'd31) state <= DONE;
        end
        DONE: begin
          bus.alu_res  <= acc;
          bus.reg2     <= l_reg2;
          bus.dest     <= l_dest;
          bus.mem_r_en <= l_mem_r;
          bus.mem_w_en <= l_mem_w;
          bus.wb_en    <= l_wb;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Directed and randomized checks of exe_stage against a behavioural model
// of the ALU commands and the multiply latency.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: command semantics straight from the instruction table.
  function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b % 32);
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd10: return a >> sh;
      4'd11: begin p = longint'(a) * longint'(b); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] d, input logic [31:0] r2, input logic [31:0] pc,
                       input logic bt, input logic mr, input logic mw, input logic wb);
    bus.exe_cmd_in = cmd; bus.val1_in = v1; bus.val2_in = v2; bus.dest_in = d;
    bus.reg2_in = r2; bus.pc_in = pc; bus.br_taken_in = bt;
    bus.mem_r_en_in = mr; bus.mem_w_en_in = mw; bus.wb_en_in = wb;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_alu"},  bus.alu_res, 32'd0);
    check({tag, "_reg2"}, bus.reg2, 32'd0);
    check({tag, "_dest"}, {27'd0, bus.dest}, 32'd0);
    check({tag, "_ctl"},  {29'd0, bus.mem_r_en, bus.mem_w_en, bus.wb_en}, 32'd0);
  endtask

  // Issue one instruction from IDLE, verify it end to end; returns just after the
  // edge where its result is visible, ready for the next instruction.
  task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [4:0] d, input logic [31:0] r2,
                       input logic mr, input logic mw, input logic wb);
    logic [31:0] pc, exp;
    int stall_cnt;
    pc = $urandom;
    exp = model(cmd, v1, v2);
    drive(cmd, v1, v2, d, r2, pc, 1'b1, mr, mw, wb);
    #1;
    check({tag, "_br_addr"}, bus.br_addr, pc + v2 * 32'd4);
    check({tag, "_br_taken"}, {31'd0, bus.br_taken}, 32'd1);
    check({tag, "_stall_issue"}, {31'd0, bus.stall}, {31'd0, cmd == 4'd11});
    if (cmd == 4'd11) begin
      stall_cnt = 1;
      for (int k = 1; k <= 32; k++) begin
        step();
        // Operands must already be latched; disturb everything but the command.
        bus.val1_in = $urandom; bus.val2_in = $urandom; bus.dest_in = 5'($urandom);
        bus.reg2_in = $urandom; bus.wb_en_in = 1'($urandom);
        #1;
        if (bus.stall) stall_cnt++;
        check({tag, "_mul_wb"}, {31'd0, bus.wb_en}, 32'd0);
        if (k == 16) check({tag, "_mul_br_taken"}, {31'd0, bus.br_taken}, 32'd0);
      end
      step();
      check({tag, "_stall_cycles"}, stall_cnt, 33);
      check({tag, "_done_stall"}, {31'd0, bus.stall}, 32'd0);
      check({tag, "_done_wb"}, {31'd0, bus.wb_en}, 32'd0);
    end
    step();
    check({tag, "_alu"},  bus.alu_res, exp);
    check({tag, "_dest"}, {27'd0, bus.dest}, {27'd0, d});
    check({tag, "_reg2"}, bus.reg2, r2);
    check({tag, "_ctl"},  {29'd0, bus.mem_r_en, bus.mem_w_en, bus.wb_en}, {29'd0, mr, mw, wb});
  endtask

  initial begin
    logic [3:0]  sweep_cmd [9];
    logic [31:0] sweep_exp [9];
    logic [3:0]  c;
    sweep_cmd = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    sweep_exp = '{32'hF0000005, 32'hEFFFFFFD, 32'h00000000, 32'hF0000005, 32'h0FFFFFFA,
                  32'hF0000005, 32'h00000010, 32'hFF000000, 32'h0F000000};

    drive(4'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step();
    check_zero_outputs("reset");
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_br_taken", {31'd0, bus.br_taken}, 32'd0);
    rst = 1'b0;

    // Branch target with a negative word offset.
    drive(4'd0, 32'd1, 32'hFFFFFFFE, 5'd0, 32'd0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("branch_addr", bus.br_addr, 32'h000000F8);
    check("branch_taken", {31'd0, bus.br_taken}, 32'd1);
    step();

    for (int i = 0; i < 9; i++) begin
      drive(sweep_cmd[i], 32'hF0000001, 32'h4, 5'(i + 1), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("sweep_%0d", i), bus.alu_res, sweep_exp[i]);
    end

    do_op("mul_neg", 4'd11, 32'h00010003, 32'hFFFFFFFF, 5'd7, 32'h0, 1'b0, 1'b0, 1'b1);
    check("mul_neg_const", bus.alu_res, 32'hFFFEFFFD);
    do_op("b2b_mul", 4'd11, 32'd3, 32'd5, 5'd3, 32'h55, 1'b0, 1'b1, 1'b1);
    check("b2b_mul_const", bus.alu_res, 32'd15);
    do_op("b2b_add", 4'd0, 32'd2, 32'd2, 5'd4, 32'h66, 1'b1, 1'b0, 1'b1);
    check("b2b_add_const", bus.alu_res, 32'd4);
    do_op("mul_mul", 4'd11, 32'h12345678, 32'h9ABCDEF1, 5'd9, 32'h1, 1'b1, 1'b0, 1'b1);

    // Reset during iteration 10 of a multiply.
    drive(4'd11, 32'd1234, 32'd5678, 5'd12, 32'hAA, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) step();
    rst = 1'b1;
    #1;
    check("rstmul_stall", {31'd0, bus.stall}, 32'd0);
    check("rstmul_br_taken", {31'd0, bus.br_taken}, 32'd0);
    step(); step();
    check_zero_outputs("rstmul");
    rst = 1'b0;
    drive(4'd4, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 36; k++) begin
      step();
      if (bus.wb_en !== 1'b0) check("rstmul_no_wb", {31'd0, bus.wb_en}, 32'd0);
    end
    check("rstmul_quiet_wb", {31'd0, bus.wb_en}, 32'd0);
    do_op("rstmul_add", 4'd0, 32'd10, 32'd20, 5'd5, 32'h7, 1'b0, 1'b0, 1'b1);

    // Randomized mix, multiplies kept rare to bound run length.
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'd11 && ($urandom_range(0, 3) != 0)) c = 4'd0;
      do_op($sformatf("rnd%0d", i), c, $urandom, $urandom, 5'($urandom), $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
